awaddr_axi_aw_issuer: RTL

- Downstream consumer of the AW-address FIFO.
- Pops write-burst descriptors ({awlen, awaddr}) from the FIFO read port, compensating for the FIFO's 1-cycle read latency with a 2-entry prefetch buffer.
- Drives the AXI3/4 AW channel to the DDR controller and tracks outstanding writes via the B channel.
- Pulses a per-burst notification for the W-channel sequencer.

---
 rtl/awaddr_axi_aw_issuer.sv | 306 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/awaddr_axi_aw_issuer.sv
// ---------------------------------------------------------------------------
// awaddr_axi_aw_issuer
//
// Purpose:
//   Drains write-burst descriptors ({awlen, awaddr}) from the AW-address FIFO
//   and issues them on the AXI AW channel toward the DDR controller. The FIFO
//   has a one-cycle read latency. A two-entry prefetch buffer hides that
//   latency. Outstanding writes are counted against the B channel, and every
//   AW handshake is announced to the W-channel sequencer with a one-cycle
//   pulse.
//
// Ports:
//   clk, rst_n        single clock, asynchronous active-low reset
//   fifo_rd_data      FIFO read data {awlen[7:0], addr[ADDR_W-1:0]}, valid the
//                     cycle after fifo_rd_en
//   fifo_rd_empty     FIFO empty flag
//   fifo_rd_en        FIFO pop request
//   axi_aw*           AXI AW channel (id/size/burst are constants)
//   axi_bvalid/bresp  AXI B channel inputs; axi_bready is held high after reset
//   aw_issued         one-cycle pulse per AW handshake
//   aw_issued_len     awlen of the burst just issued, valid with aw_issued
//   outstanding       AW handshakes still waiting for a B response
//   wr_resp_err       sticky flag for any SLVERR/DECERR response
//   idle              buffer empty, no read in flight, nothing outstanding
// ---------------------------------------------------------------------------
module awaddr_axi_aw_issuer #(
  parameter int unsigned     ADDR_W          = 24,
  parameter int unsigned     ID_W            = 4,
  parameter logic [ID_W-1:0] AW_ID           = {ID_W{1'b0}},
  parameter logic [2:0]      AW_SIZE         = 3'b011,
  parameter int unsigned     MAX_OUTSTANDING = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W+7:0] fifo_rd_data,
  input  logic              fifo_rd_empty,
  output logic              fifo_rd_en,
  output logic [ID_W-1:0]   axi_awid,
  output logic [ADDR_W-1:0] axi_awaddr,
  output logic [7:0]        axi_awlen,
  output logic [2:0]        axi_awsize,
  output logic [1:0]        axi_awburst,
  output logic              axi_awvalid,
  input  logic              axi_awready,
  input  logic              axi_bvalid,
  input  logic [1:0]        axi_bresp,
  output logic              axi_bready,
  output logic              aw_issued,
  output logic [7:0]        aw_issued_len,
  output logic [7:0]        outstanding,
  output logic              wr_resp_err,
  output logic              idle
);

  localparam int unsigned ENTRY_W   = ADDR_W + 8;
  localparam logic [7:0]  MAX_OUT_C = MAX_OUTSTANDING[7:0];

  typedef enum logic {
    AW_IDLE  = 1'b0,
    AW_VALID = 1'b1
  } aw_state_e;

  // Registered state
  logic               run_r;          // low in reset, high from the first edge after release
  logic               rd_inflight_r;  // last cycle's fifo_rd_en: data is on fifo_rd_data now
  logic [ENTRY_W-1:0] buf_mem_r [2];
  logic               head_r;
  logic               tail_r;
  logic [1:0]         buf_count_r;
  aw_state_e          aw_state_r;
  logic [ADDR_W-1:0]  awaddr_r;
  logic [7:0]         awlen_r;
  logic [7:0]         outstanding_r;
  logic               aw_issued_r;
  logic [7:0]         aw_issued_len_r;
  logic               wr_resp_err_r;
  logic               idle_r;

  // Combinational signals
  logic               rd_en_s;
  logic               aw_hs_s;
  logic               b_hs_s;
  logic               resp_err_s;
  logic               buf_push_s;
  logic               buf_pop_s;
  logic [1:0]         buf_count_nxt_s;
  logic [1:0]         buf_remain_s;
  logic               head_sel_s;
  logic [ENTRY_W-1:0] next_entry_s;
  logic               out_inc_s;
  logic               out_dec_s;
  logic [7:0]         outstanding_nxt_s;
  aw_state_e          aw_state_nxt_s;
  logic [ADDR_W-1:0]  awaddr_nxt_s;
  logic [7:0]         awlen_nxt_s;
  logic               idle_nxt_s;

  // Handshake decode and prefetch credit. The credit counts a read that is
  // still in flight, so a pop only frees a slot once its data has landed.
  always_comb begin
    rd_en_s    = 1'b0;
    aw_hs_s    = 1'b0;
    b_hs_s     = 1'b0;
    resp_err_s = 1'b0;
    if (run_r && !fifo_rd_empty &&
        (({1'b0, buf_count_r} + {2'b00, rd_inflight_r}) < 3'd2)) begin
      rd_en_s = 1'b1;
    end else begin
      rd_en_s = 1'b0;
    end
    aw_hs_s    = (aw_state_r == AW_VALID) && axi_awready;
    b_hs_s     = axi_bvalid && run_r;
    resp_err_s = b_hs_s && ((axi_bresp == 2'b10) || (axi_bresp == 2'b11));
  end

  // Prefetch buffer bookkeeping: push on landing read data, pop on AW handshake.
  always_comb begin
    buf_push_s      = rd_inflight_r;
    buf_pop_s       = aw_hs_s;
    buf_count_nxt_s = buf_count_r;
    case ({buf_push_s, buf_pop_s})
      2'b10:   buf_count_nxt_s = buf_count_r + 2'd1;
      2'b01:   buf_count_nxt_s = buf_count_r - 2'd1;
      default: buf_count_nxt_s = buf_count_r;
    endcase
    // Entries eligible for the next AW decision exclude data landing this
    // cycle; that entry is only visible once it sits in the buffer.
    buf_remain_s = buf_count_r - {1'b0, buf_pop_s};
    head_sel_s   = buf_pop_s ? ~head_r : head_r;
    next_entry_s = buf_mem_r[head_sel_s];
  end

  // Outstanding counter update; increment is blocked at the limit and a
  // stray B response at zero leaves the count at zero.
  always_comb begin
    out_inc_s         = aw_hs_s && (outstanding_r < MAX_OUT_C);
    out_dec_s         = b_hs_s && (outstanding_r != 8'd0);
    outstanding_nxt_s = outstanding_r;
    case ({out_inc_s, out_dec_s})
      2'b10:   outstanding_nxt_s = outstanding_r + 8'd1;
      2'b01:   outstanding_nxt_s = outstanding_r - 8'd1;
      default: outstanding_nxt_s = outstanding_r;
    endcase
  end

  // AW channel next state. The limit is checked against the post-update
  // count so a handshake this cycle cannot push the count past the limit.
  always_comb begin
    aw_state_nxt_s = aw_state_r;
    awaddr_nxt_s   = awaddr_r;
    awlen_nxt_s    = awlen_r;
    case (aw_state_r)
      AW_IDLE: begin
        if ((buf_count_r != 2'd0) && (outstanding_nxt_s < MAX_OUT_C)) begin
          aw_state_nxt_s = AW_VALID;
          awaddr_nxt_s   = next_entry_s[ADDR_W-1:0];
          awlen_nxt_s    = next_entry_s[ENTRY_W-1:ADDR_W];
        end else begin
          aw_state_nxt_s = AW_IDLE;
        end
      end
      AW_VALID: begin
        if (axi_awready) begin
          if ((buf_remain_s != 2'd0) && (outstanding_nxt_s < MAX_OUT_C)) begin
            aw_state_nxt_s = AW_VALID;
            awaddr_nxt_s   = next_entry_s[ADDR_W-1:0];
            awlen_nxt_s    = next_entry_s[ENTRY_W-1:ADDR_W];
          end else begin
            aw_state_nxt_s = AW_IDLE;
          end
        end else begin
          // Payload is frozen while waiting for awready.
          aw_state_nxt_s = AW_VALID;
        end
      end
      default: begin
        aw_state_nxt_s = AW_IDLE;
      end
    endcase
  end

  // Idle is true when nothing is buffered, in flight or outstanding.
  always_comb begin
    if ((buf_count_nxt_s == 2'd0) && !rd_en_s && (outstanding_nxt_s == 8'd0)) begin
      idle_nxt_s = 1'b1;
    end else begin
      idle_nxt_s = 1'b0;
    end
  end

  // Run enable and in-flight read tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_r         <= 1'b0;
      rd_inflight_r <= 1'b0;
    end else begin
      run_r         <= 1'b1;
      rd_inflight_r <= rd_en_s;
    end
  end

  // Prefetch buffer storage and pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_mem_r[0] <= {ENTRY_W{1'b0}};
      buf_mem_r[1] <= {ENTRY_W{1'b0}};
      head_r       <= 1'b0;
      tail_r       <= 1'b0;
      buf_count_r  <= 2'd0;
    end else begin
      if (buf_push_s) begin
        buf_mem_r[tail_r] <= fifo_rd_data;
        tail_r            <= ~tail_r;
      end
      if (buf_pop_s) begin
        head_r <= ~head_r;
      end
      buf_count_r <= buf_count_nxt_s;
    end
  end

  // AW channel state and payload registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_state_r <= AW_IDLE;
      awaddr_r   <= {ADDR_W{1'b0}};
      awlen_r    <= 8'd0;
    end else begin
      aw_state_r <= aw_state_nxt_s;
      awaddr_r   <= awaddr_nxt_s;
      awlen_r    <= awlen_nxt_s;
    end
  end

  // Issue notification, outstanding count, error flag and idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_issued_r     <= 1'b0;
      aw_issued_len_r <= 8'd0;
      outstanding_r   <= 8'd0;
      wr_resp_err_r   <= 1'b0;
      idle_r          <= 1'b1;
    end else begin
      aw_issued_r <= aw_hs_s;
      if (aw_hs_s) begin
        aw_issued_len_r <= awlen_r;
      end
      outstanding_r <= outstanding_nxt_s;
      if (resp_err_s) begin
        wr_resp_err_r <= 1'b1;
      end
      idle_r <= idle_nxt_s;
    end
  end

  assign fifo_rd_en    = rd_en_s;
  assign axi_awid      = AW_ID;
  assign axi_awaddr    = awaddr_r;
  assign axi_awlen     = awlen_r;
  assign axi_awsize    = AW_SIZE;
  assign axi_awburst   = 2'b01;
  assign axi_awvalid   = (aw_state_r == AW_VALID);
  assign axi_bready    = run_r;
  assign aw_issued     = aw_issued_r;
  assign aw_issued_len = aw_issued_len_r;
  assign outstanding   = outstanding_r;
  assign wr_resp_err   = wr_resp_err_r;
  assign idle          = idle_r;

  awaddr_axi_aw_issuer_chk u_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .b_hs        (b_hs_s),
    .outstanding (outstanding_r),
    .buf_count   (buf_count_r)
  );

endmodule

// ---------------------------------------------------------------------------
// awaddr_axi_aw_issuer_chk
//
// Purpose: protocol and structural checks for awaddr_axi_aw_issuer.
// Ports:
//   clk, rst_n    clock and reset of the checked block
//   b_hs          B-channel handshake
//   outstanding   current outstanding count
//   buf_count     prefetch buffer occupancy
// ---------------------------------------------------------------------------
module awaddr_axi_aw_issuer_chk (
  input logic       clk,
  input logic       rst_n,
  input logic       b_hs,
  input logic [7:0] outstanding,
  input logic [1:0] buf_count
);

  // A B response with nothing outstanding is a downstream protocol error.
  a_b_without_aw : assert property (@(posedge clk) disable iff (!rst_n)
    b_hs |-> (outstanding != 8'd0));

  // The credit rule keeps the two-entry buffer from overflowing.
  a_buf_bound : assert property (@(posedge clk) disable iff (!rst_n)
    buf_count <= 2'd2);

endmodule
